// File: rtl/spawn_pkg.sv
// Shared definitions for the spawn scheduler: state codes, lane indices,
// timer width and a saturating timer increment.
package spawn_pkg;

  localparam int TIMER_W   = 10;
  localparam int NUM_LANES = 3;

  localparam int FWD   = 0;
  localparam int LEFT  = 1;
  localparam int RIGHT = 2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_DELAY    = 3'b001,
    S_ARB      = 3'b010,
    S_COOLDOWN = 3'b011,
    S_WAVE_END = 3'b100,
    S_DONE     = 3'b101
  } sched_state_t;

  typedef logic [TIMER_W-1:0] timer_t;

  function automatic timer_t timer_inc(input timer_t t);
    return (t == '1) ? t : t + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-lane spawn arbiter. SPAWN_SCHED_RR_EN selects round-robin with a
// last-grant pointer; otherwise fixed priority forward > left > right.
module rr_arbiter3
  import spawn_pkg::*;
(
`ifdef SPAWN_SCHED_RR_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       update,
`endif
  input  logic [2:0] req,
  output logic [2:0] grant
);

`ifdef SPAWN_SCHED_RR_EN
  logic [1:0] ptr;
  logic [1:0] cand;
  logic       found;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = (ptr == 2'(RIGHT)) ? 2'(FWD) : ptr + 2'd1;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        found       = 1'b1;
      end
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 2'(RIGHT);
    end else if (update && (grant != '0)) begin
      ptr <= grant[RIGHT] ? 2'd2 : (grant[LEFT] ? 2'd1 : 2'd0);
    end
  end
`else
  always_comb begin
    grant = '0;
    if (req[FWD])        grant[FWD]   = 1'b1;
    else if (req[LEFT])  grant[LEFT]  = 1'b1;
    else if (req[RIGHT]) grant[RIGHT] = 1'b1;
  end
`endif

endmodule

// File: rtl/spawn_scheduler.sv
// Wave-based enemy spawn scheduler: delay, arbitrate, cool down, repeat per wave.
// Round-robin lane selection is enabled by defining SPAWN_SCHED_RR_EN.
module spawn_scheduler
  import spawn_pkg::*;
#(
  parameter int FIRST_DELAY = 6,
  parameter int SPAWN_GAP   = 500,
  parameter int WAVE_SIZE   = 3,
  parameter int NUM_WAVES   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic [2:0] spawn_req,
  input  logic [2:0] kill,
  output logic [2:0] spawn_grant,
  output logic [2:0] active,
  output logic [2:0] sched_state,
  output logic [1:0] wave_num,
  output logic       wave_done,
  output logic       all_clear
);

  localparam timer_t     FIRST_T   = TIMER_W'(FIRST_DELAY);
  localparam timer_t     GAP_T     = TIMER_W'(SPAWN_GAP);
  localparam logic [1:0] WAVE_SZ   = 2'(WAVE_SIZE);
  localparam logic [1:0] LAST_WAVE = 2'(NUM_WAVES - 1);

  sched_state_t state;
  timer_t       timer;
  timer_t       next_timer;
  logic [1:0]   lane_count [NUM_LANES];
  logic [2:0]   eligible;
  logic [2:0]   arb_grant;
  logic [2:0]   kill_clr;
  logic         do_grant;
  logic         lanes_full;

  assign sched_state = state;

  always_comb begin
    eligible   = '0;
    lanes_full = 1'b1;
    for (int i = 0; i < NUM_LANES; i++) begin
      eligible[i] = spawn_req[i] && !active[i] && (lane_count[i] < WAVE_SZ);
      if (lane_count[i] != WAVE_SZ) lanes_full = 1'b0;
    end
    do_grant   = (state == S_ARB) && tick && (eligible != '0);
    kill_clr   = (state != S_IDLE) ? (kill & active) : '0;
    next_timer = timer_inc(timer);
  end

  rr_arbiter3 u_arb (
`ifdef SPAWN_SCHED_RR_EN
    .clk    (clk),
    .rst_n  (rst_n),
    .update (do_grant),
`endif
    .req    (eligible),
    .grant  (arb_grant)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      timer       <= '0;
      // NOTE: the per-lane counters gate eligibility, so unlike a data memory they must be reset.
      lane_count  <= '{default: '0};
      spawn_grant <= '0;
      active      <= '0;
      wave_num    <= '0;
      wave_done   <= 1'b0;
      all_clear   <= 1'b0;
    end else begin
      spawn_grant <= '0;
      wave_done   <= 1'b0;
      // A lane killed this cycle drops out on this edge; a new grant is never on a live lane.
      active      <= (active & ~kill_clr) | (do_grant ? arb_grant : 3'b000);

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_DELAY;
            timer      <= '0;
            lane_count <= '{default: '0};
            wave_num   <= '0;
            all_clear  <= 1'b0;
          end
        end

        S_DELAY: begin
          if (tick) begin
            if (next_timer == FIRST_T) begin
              state <= S_ARB;
              timer <= '0;
            end else begin
              timer <= next_timer;
            end
          end
        end

        S_ARB: begin
          if (do_grant) begin
            spawn_grant <= arb_grant;
            for (int i = 0; i < NUM_LANES; i++) begin
              if (arb_grant[i] && (lane_count[i] != 2'b11)) lane_count[i] <= lane_count[i] + 2'd1;
            end
            state <= S_COOLDOWN;
            timer <= '0;
          end else if (lanes_full && (active == '0)) begin
            state     <= S_WAVE_END;
            wave_done <= 1'b1;
            timer     <= '0;
          end
        end

        S_COOLDOWN: begin
          if (tick) begin
            if (next_timer == GAP_T) begin
              state <= S_ARB;
              timer <= '0;
            end else begin
              timer <= next_timer;
            end
          end
        end

        S_WAVE_END: begin
          timer <= '0;
          if (wave_num == LAST_WAVE) begin
            state     <= S_DONE;
            all_clear <= 1'b1;
          end else begin
            if (wave_num != 2'b11) wave_num <= wave_num + 2'd1;
            lane_count <= '{default: '0};
            state      <= S_DELAY;
          end
        end

        default: begin
          state <= S_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule
